// File: rtl/cpu_sequencer_if.sv
// Instruction-memory fetch channel between the sequencer (master) and imem (slave).
interface cpu_sequencer_if #(
  parameter int PC_W = 8
) ();
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  logic [15:0]     rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit datapath: owns PC/IR, fetches over
// req/ack, gates register-file and data-RAM write enables, resolves branches.
module cpu_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  cpu_sequencer_if.master  imem,
  output logic [15:0]      inst,
  input  logic             ld_in,
  input  logic             mw_in,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             rf_we,
  output logic             dmem_we,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;

  localparam logic [3:0] OP_HALT = 4'b0001;
  localparam logic [3:0] OP_LB   = 4'b0010;
  localparam logic [3:0] OP_SB   = 4'b0100;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_r, state_nx_s;
  logic [PC_W-1:0]  pc_r, pc_nx_s;
  logic [15:0]      inst_r, inst_nx_s;
  logic [CNT_W-1:0] retired_r, retired_nx_s;
  logic [3:0]       opcode_s;

  // Branch offset: 6-bit immediate sign-extended to the PC width
  function automatic logic [PC_W-1:0] imm_sext(input logic [15:0] ir);
    return {{(PC_W-6){ir[5]}}, ir[5:0]};
  endfunction

  // Low two opcode bits pick BEQ / BNE / BGEZ / BLTZ
  function automatic logic branch_taken(input logic [1:0] cond, input logic zero, input logic neg);
    logic taken;
    case (cond)
      2'b00:   taken = zero;
      2'b01:   taken = ~zero;
      2'b10:   taken = ~neg;
      2'b11:   taken = neg;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  assign opcode_s = inst_r[15:12];

  // Next-state, PC, IR and retire-count computation
  always_comb begin
    state_nx_s   = state_r;
    pc_nx_s      = pc_r;
    inst_nx_s    = inst_r;
    retired_nx_s = retired_r;
    case (state_r)
      ST_IDLE: begin
        if (run) state_nx_s = ST_FETCH;
        else     state_nx_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem.ack) begin
          inst_nx_s  = imem.rdata;
          state_nx_s = ST_DECODE;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (opcode_s == OP_HALT) state_nx_s = ST_HALTED;
        else                     state_nx_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (opcode_s[3:2] == 2'b10) begin
          if (branch_taken(opcode_s[1:0], alu_zero, alu_neg))
            pc_nx_s = pc_r + PC_ONE + imm_sext(inst_r);
          else
            pc_nx_s = pc_r + PC_ONE;
          retired_nx_s = retired_r + CNT_ONE;
          state_nx_s   = ST_FETCH;
        end else if ((opcode_s == OP_LB) || (opcode_s == OP_SB)) begin
          state_nx_s = ST_MEM;
        end else begin
          state_nx_s = ST_WB;
        end
      end
      ST_MEM: begin
        // Stores retire here; loads still need the register write-back
        if (opcode_s == OP_SB) begin
          pc_nx_s      = pc_r + PC_ONE;
          retired_nx_s = retired_r + CNT_ONE;
          state_nx_s   = ST_FETCH;
        end else begin
          state_nx_s = ST_WB;
        end
      end
      ST_WB: begin
        pc_nx_s      = pc_r + PC_ONE;
        retired_nx_s = retired_r + CNT_ONE;
        state_nx_s   = ST_FETCH;
      end
      ST_HALTED: begin
        state_nx_s = ST_HALTED;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pc_r      <= {PC_W{1'b0}};
      inst_r    <= 16'h0000;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      pc_r      <= pc_nx_s;
      inst_r    <= inst_nx_s;
      retired_r <= retired_nx_s;
    end
  end

  // Write enables pass the decoder request only in their own phase
  always_comb begin
    if (state_r == ST_WB) rf_we = ld_in;
    else                  rf_we = 1'b0;
    if (state_r == ST_MEM) dmem_we = mw_in;
    else                   dmem_we = 1'b0;
  end

  assign imem.req  = (state_r == ST_FETCH);
  assign imem.addr = pc_r;
  assign inst      = inst_r;
  assign pc        = pc_r;
  assign halted    = (state_r == ST_HALTED);
  assign state_o   = state_r;
  assign retired   = retired_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed and random instruction
// streams compared against an instruction-level reference model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] inst;
  logic        ld_in, mw_in, alu_zero, alu_neg;
  logic        rf_we, dmem_we;
  logic [7:0]  pc;
  logic        halted;
  logic [2:0]  state_o;
  logic [15:0] retired;

  cpu_sequencer_if #(.PC_W(8)) imem_bus ();

  cpu_sequencer #(.PC_W(8), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .imem     (imem_bus.master),
    .inst     (inst),
    .ld_in    (ld_in),
    .mw_in    (mw_in),
    .alu_zero (alu_zero),
    .alu_neg  (alu_neg),
    .rf_we    (rf_we),
    .dmem_we  (dmem_we),
    .pc       (pc),
    .halted   (halted),
    .state_o  (state_o),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  logic [7:0]  model_pc;
  logic [15:0] model_ret;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Runs one instruction starting at the negedge of its first FETCH cycle and
  // returns at the negedge where the next FETCH (or HALTED) begins.
  task automatic do_instr(input logic [15:0] instr, input int waits,
                          input logic z, input logic n, input logic ld, input logic mw);
    logic [3:0] op;
    int  exp_cyc, exp_rf_at, exp_dm_at, s, cyc, wcnt, rf_cnt, rf_at, dm_cnt, dm_at;
    logic taken, is_halt, is_br, fetched, done;
    logic [7:0] exp_pc;

    op = instr[15:12];
    mem[model_pc] = instr;
    alu_zero = z; alu_neg = n; ld_in = ld; mw_in = mw;

    is_halt = (op == 4'h1);
    is_br   = (op >= 4'h8) && (op <= 4'hB);
    case (op)
      4'h8:    taken = z;
      4'h9:    taken = !z;
      4'hA:    taken = !n;
      4'hB:    taken = n;
      default: taken = 1'b0;
    endcase
    s = int'(instr[5:0]);
    if (s >= 32) s = s - 64;
    exp_rf_at = 0;
    exp_dm_at = 0;
    if (is_halt)           exp_cyc = 2;
    else if (is_br)        exp_cyc = 3;
    else if (op == 4'h2)   exp_cyc = 5;
    else                   exp_cyc = 4;
    exp_cyc = exp_cyc + waits;
    if (!is_halt && !is_br && op != 4'h4 && ld) exp_rf_at = exp_cyc;
    if ((op == 4'h2 || op == 4'h4) && mw)       exp_dm_at = 4 + waits;
    exp_pc = is_halt ? model_pc : 8'((int'(model_pc) + 1 + (taken ? s : 0)) & 255);

    chk("fetch_req", imem_bus.req, 1);
    chk("fetch_addr", imem_bus.addr, model_pc);

    cyc = 0; wcnt = 0; rf_cnt = 0; rf_at = 0; dm_cnt = 0; dm_at = 0;
    fetched = 0; done = 0;
    while (!done && cyc < 100) begin
      cyc++;
      if (rf_we)   begin rf_cnt++; rf_at = cyc; end
      if (dmem_we) begin dm_cnt++; dm_at = cyc; end
      if (imem_bus.req) begin
        if (wcnt == waits) begin
          imem_bus.ack   = 1'b1;
          imem_bus.rdata = mem[imem_bus.addr];
          fetched = 1;
        end else begin
          imem_bus.ack   = 1'b0;
          imem_bus.rdata = 16'($urandom);
          wcnt++;
        end
      end else begin
        // Stray acks with junk data outside FETCH must not disturb IR
        imem_bus.ack   = 1'($urandom);
        imem_bus.rdata = 16'($urandom);
      end
      @(negedge clk);
      if (fetched && (state_o == 3'd1 || state_o == 3'd6)) done = 1;
    end
    imem_bus.ack = 1'b0;

    chk("no_timeout", done, 1);
    chk("cycles", cyc, exp_cyc);
    chk("rf_we_count", rf_cnt, (exp_rf_at != 0) ? 1 : 0);
    chk("rf_we_cycle", rf_at, exp_rf_at);
    chk("dmem_we_count", dm_cnt, (exp_dm_at != 0) ? 1 : 0);
    chk("dmem_we_cycle", dm_at, exp_dm_at);
    chk("inst", inst, instr);
    chk("pc", pc, exp_pc);
    if (!is_halt) model_ret = model_ret + 16'd1;
    chk("retired", retired, model_ret);
    chk("halted", halted, is_halt);
    model_pc = exp_pc;
  endtask

  initial begin
    logic [3:0] rop;
    rst_n = 1'b0; run = 1'b0;
    ld_in = 1'b0; mw_in = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
    imem_bus.ack = 1'b0; imem_bus.rdata = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    model_pc = 8'h00; model_ret = 16'h0000;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_req", imem_bus.req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_inst", inst, 0);
    chk("rst_retired", retired, 0);
    chk("rst_we", {rf_we, dmem_we, halted}, 0);

    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("start_state", state_o, 1);

    // Directed steps: ALU timing, branches, wrap both ways, load/store
    do_instr(16'h5246, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_instr(16'h803E, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr(16'h5246, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    do_instr(16'h803E, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(16'h2123, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_instr(16'h4123, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    do_instr(16'hB038, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_instr(16'hB005, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_instr(16'h903A, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pc_wrapped", pc, 0);

    // Random instruction stream (HALT excluded)
    for (int k = 0; k < 40; k++) begin
      rop = 4'($urandom_range(0, 15));
      if (rop == 4'h1) rop = 4'h0;
      do_instr({rop, 12'($urandom)}, $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    do_instr(16'h1000, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("halt_state", state_o, 6);

    // HALTED is sticky: run pulses and acks are ignored
    for (int k = 0; k < 4; k++) begin
      run = 1'b1;
      imem_bus.ack = 1'b1;
      imem_bus.rdata = 16'($urandom);
      @(negedge clk);
    end
    run = 1'b0; imem_bus.ack = 1'b0;
    chk("halt_sticky_state", state_o, 6);
    chk("halt_sticky_pc", pc, model_pc);
    chk("halt_sticky_ret", retired, model_ret);
    chk("halt_sticky_inst", inst, 16'h1000);

    // Async reset while a fetch is outstanding
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("mid_fetch_req", imem_bus.req, 1);
    #2;
    rst_n = 1'b0;
    imem_bus.ack = 1'b1;
    imem_bus.rdata = 16'hFFFF;
    #1;
    chk("async_state", state_o, 0);
    chk("async_req", imem_bus.req, 0);
    chk("async_pc", pc, 0);
    chk("async_ret", retired, 0);
    chk("async_halted", halted, 0);
    repeat (2) @(negedge clk);
    chk("rst_ack_inst", inst, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_inst", inst, 0);
    chk("post_rst_state", state_o, 0);
    imem_bus.ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
